// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter generator.
// Kept separate so the selector, the register file and the bench agree on encodings.
package pc_pkg;

  typedef enum logic {
    NORMAL  = 1'b0,
    HANDLER = 1'b1
  } pc_state_t;

  // Which source produced the next pc; exported for debug observation only.
  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_SEQ    = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_EXC    = 3'd3,
    SEL_ERET   = 3'd4
  } pc_sel_t;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] PC_EXC_VEC   = 32'h0000_4180;
  localparam int          PC_STEP      = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-pc / next-state selection for pc_gen.
// Also produces the sequential address and the misalignment flag from the current pc.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(PC_EXC_VEC),
  parameter int               STEP    = PC_STEP
) (
  input  pc_state_t        state,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] epc,
  input  logic             en,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic             eret,
  output logic [WIDTH-1:0] pc_seq,
  output logic             misalign,
  output logic [WIDTH-1:0] next_pc,
  output logic [WIDTH-1:0] next_epc,
  output pc_state_t        next_state,
  output pc_sel_t          sel
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  // Plain modular add: running off the top of the address space wraps silently.
  assign pc_seq   = pc + STEP_W;
  assign misalign = (pc % STEP_W) != '0;

  // Request semantics: br_valid, exc_req and eret are single-cycle requests
  // sampled on the rising edge; there is no ready, a request is either acted on
  // at that edge or dropped. exc_req only counts in NORMAL and eret only in
  // HANDLER; an accepted one overrides en, so a stall never hides it.
  always_comb begin
    next_pc    = pc;
    next_epc   = epc;
    next_state = state;
    sel        = SEL_HOLD;

    if (state == NORMAL && exc_req) begin
      next_pc    = EXC_VEC;
      next_epc   = pc;
      next_state = HANDLER;
      sel        = SEL_EXC;
    end else if (state == HANDLER && eret) begin
      next_pc    = epc;
      next_state = NORMAL;
      sel        = SEL_ERET;
    end else if (en) begin
      if (br_valid) begin
        // Targets are taken verbatim; alignment is reported, never enforced.
        next_pc = br_target;
        sel     = SEL_BRANCH;
      end else begin
        next_pc = pc_seq;
        sel     = SEL_SEQ;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: pc/epc/state registers around pc_next_sel.
// Reset is asynchronous active-low and forces the reset vector into both pc and epc.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC),
  parameter int               STEP      = PC_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_seq,
  output logic [WIDTH-1:0] epc,
  output logic             in_handler,
  output logic             misalign,
  output pc_state_t        dbg_state,
  output pc_sel_t          dbg_sel
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] epc_q;
  pc_state_t        state_q;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] next_epc;
  pc_state_t        next_state;

  pc_next_sel #(
    .WIDTH   (WIDTH),
    .EXC_VEC (EXC_VEC),
    .STEP    (STEP)
  ) u_next_sel (
    .state      (state_q),
    .pc         (pc_q),
    .epc        (epc_q),
    .en         (en),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .exc_req    (exc_req),
    .eret       (eret),
    .pc_seq     (pc_seq),
    .misalign   (misalign),
    .next_pc    (next_pc),
    .next_epc   (next_epc),
    .next_state (next_state),
    .sel        (dbg_sel)
  );

  // Reset mid-handler drops the saved return address along with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_VEC;
      epc_q   <= RESET_VEC;
      state_q <= NORMAL;
    end else begin
      pc_q    <= next_pc;
      epc_q   <= next_epc;
      state_q <= next_state;
    end
  end

  assign pc         = pc_q;
  assign epc        = epc_q;
  assign in_handler = (state_q == HANDLER);
  assign dbg_state  = state_q;

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL expose parameter WIDTH, default 32, meaning PC and target width in bits.
REQ-002 SHALL expose parameter RESET_VEC, default 32'h0000_3000, meaning PC value while and after reset.
REQ-003 SHALL expose parameter EXC_VEC, default 32'h0000_4180, meaning exception handler entry address.
REQ-004 SHALL expose parameter STEP, default 4, meaning sequential increment in bytes.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous, active-low reset (0 = in reset).
REQ-007 SHALL have port en, input, 1, meaning 1 = advance PC, 0 = stall (hold).
REQ-008 SHALL have port br_valid, input, 1, meaning a branch/jump redirect is requested this cycle.
REQ-009 SHALL have port br_target, input, WIDTH, meaning the redirect address.
REQ-010 SHALL have port exc_req, input, 1, meaning an exception is requested this cycle.
REQ-011 SHALL have port eret, input, 1, meaning return-from-exception is requested this cycle.
REQ-012 SHALL have port pc, output, WIDTH, meaning the registered current fetch address.
REQ-013 SHALL have port pc_seq, output, WIDTH, meaning pc + STEP, combinational, modulo 2^WIDTH.
REQ-014 SHALL have port epc, output, WIDTH, meaning the registered exception return address.
REQ-015 SHALL have port in_handler, output, 1, meaning 1 when state = HANDLER.
REQ-016 SHALL have port misalign, output, 1, meaning pc mod STEP != 0, combinational from pc.

Function
REQ-017 SHALL implement a two-state machine: NORMAL, HANDLER; in_handler = (state == HANDLER).
REQ-018 In NORMAL with exc_req=1: pc <= EXC_VEC, epc <= pc, state <= HANDLER, regardless of en, br_valid, eret.
REQ-019 In HANDLER, exc_req SHALL be ignored (no nesting); epc holds.
REQ-020 In HANDLER with eret=1: pc <= epc, state <= NORMAL, regardless of en and br_valid.
REQ-021 In NORMAL, eret SHALL be ignored (treated as 0).
REQ-022 Absent an accepted exc_req/eret: en=1 and br_valid=1 -> pc <= br_target; en=1 and br_valid=0 -> pc <= pc_seq; en=0 -> pc holds, br_valid ignored.
REQ-023 Priority SHALL be: accepted exc_req > accepted eret > br_valid > sequential; a stall never masks exc_req or eret.
REQ-024 Redirect latency SHALL be one cycle: a request sampled at edge N is visible on pc after edge N.
REQ-025 pc_seq SHALL wrap modulo 2^WIDTH (all-ones region + STEP wraps to low addresses, no flag).
REQ-026 br_target SHALL be loaded verbatim even if misaligned; misalign then asserts until pc is realigned; no trap is raised internally.
REQ-027 epc SHALL change only on an accepted exception.

Reset
REQ-028 While reset=0: pc = RESET_VEC, epc = RESET_VEC, state = NORMAL, asynchronously, independent of clk.
REQ-029 Reset release SHALL take effect at the next rising clk edge; the first edge with reset=1 applies normal update rules.
REQ-030 Reset asserted mid-handler SHALL abandon HANDLER immediately and discard epc.

Structure
REQ-031 A shared package pc_pkg SHALL hold the state enum (NORMAL, HANDLER) and the default RESET_VEC/EXC_VEC/STEP constants.
REQ-032 One combinational sub-module pc_next_sel SHALL compute the next-pc and next-state selection; pc_gen holds only the registers.

Verification
REQ-033 reset=0 then release, en=1 for 3 edges -> pc 0x3000, 0x3004, 0x3008, 0x300C.
REQ-034 pc=0x3008, en=0, br_valid=1, br_target=0x3100 for 2 edges -> pc stays 0x3008; then en=1 -> pc 0x3100.
REQ-035 pc=0x3010, en=0, exc_req=1, br_valid=1 -> pc 0x4180, epc 0x3010, in_handler=1; second exc_req in handler -> epc still 0x3010.
REQ-036 In HANDLER, eret=1 with br_valid=1, br_target=0x5000 -> pc 0x3010, in_handler=0; eret in NORMAL -> pc advances by 4.
REQ-037 br_target=0x3102 -> misalign=1; next en=1 -> pc 0x3106, misalign=1; WIDTH=32, pc=0xFFFF_FFFC, en=1 -> pc 0x0000_0000.
REQ-038 reset pulsed low mid-cycle while in HANDLER -> pc 0x3000, epc 0x3000, in_handler=0 before the next clk edge.
